uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

UART receiver with a small first-word-fall-through FIFO. It sits directly downstream of the `tt_um_example` pad inputs: serial data arrives on one `ui_in` bit, and the core logic inside the top level pops received bytes at its own pace. Format is 8-N-1, LSB first, idle-high line. An optional parity bit is selectable at compile time.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Must be even and ≥ 4.
- `DEPTH`, default 4: FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ena`  in  1  design enable. Low forces the receiver to IDLE; FIFO contents are kept and reads still work.
- `rx`  in  1  asynchronous serial input; idles high.
- `rd_en`  in  1  pop request. Ignored when `empty`=1.
- `rd_data`  out  8  FIFO head. Valid while `empty`=0.
- `empty`  out  1  FIFO holds no bytes.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `overrun`  out  1  one-cycle pulse: a completed byte was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low; the byte is dropped.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; the byte is dropped. Tied 0 when parity is compiled out.

## Operation
- Input path: `rx` passes through a 2-flop synchronizer. Both flops reset to 1.
- States: IDLE, START, DATA, (PARITY), STOP.
- IDLE:
  - Waits for a falling edge on the synchronized `rx`.
  - On the edge, loads the bit counter with `CLKS_PER_BIT/2-1` and enters START.
- START:
  - At counter expiry (mid start bit), synchronized `rx`=0 enters DATA.
  - `rx`=1 is a glitch: return to IDLE with no error.
- DATA:
  - Samples at each mid-bit, every `CLKS_PER_BIT` cycles.
  - Shifts in LSB first; bit index runs 0..7.
  - After bit 7, goes to PARITY if compiled in, else STOP.
- PARITY: samples the parity bit and compares it to the even parity of the data; a mismatch sets an internal error flag.
- STOP: samples the stop bit, then returns to IDLE in the same edge. The outcome is decided by this priority:
  1. Stop bit = 0: `frame_err` pulse.
  2. Else parity flag set: `parity_err` pulse.
  3. Else FIFO full and no same-cycle pop: `overrun` pulse.
  4. Otherwise the byte is pushed.
- FIFO:
  - Read and write pointers are `log2(DEPTH)+1` bits; they wrap modulo `2*DEPTH`.
  - `empty` is true when the pointers are equal.
  - `full` is true when the MSBs differ and the lower bits are equal.
  - Push and pop in the same cycle are both accepted, including when full. The count is then unchanged.
- `ena`=0 in any state: next state is IDLE, counters clear, the partial byte is discarded, and no error pulses fire.
- Reset mid-frame:
  - Pointers clear (FIFO empty) and the FSM goes to IDLE.
  - The rest of the frame then on the line is ignored until a fresh falling edge is seen in IDLE. A falling edge from a data bit can be taken as a false start; that behaviour is acceptable.

## Timing
- Reset values:
  - `empty`=1, `full`=0.
  - `rd_data`=8'h00 (storage cleared).
  - `overrun`=`frame_err`=`parity_err`=0.
  - FSM in IDLE; synchronizer flops at 1.
- Start detection: 2–3 clocks after the `rx` pad falls (synchronizer plus edge detect).
- Push latency: the push occurs on the edge at mid-stop-bit. `empty` falls and `rd_data` is valid on that same edge (registered outputs).
- Pop: on the edge where `rd_en`=1 and `empty`=0, the head advances. The new `rd_data`/`empty` are visible right after that edge.
- Error pulses are exactly one clock wide and coincide with the mid-stop sampling edge.
- Throughput: back-to-back frames with no idle gap are received. IDLE re-arms in the cycle after STOP.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - A PARITY state is inserted after DATA.
  - Frame is 8-E-1: 11 bits, with even parity over the 8 data bits.
  - `parity_err` is live.
- Not defined:
  - No PARITY state and no parity logic; frame is 8-N-1 (10 bits).
  - `parity_err` is constant 0.

## Test plan
All scenarios use `CLKS_PER_BIT`=8 and `DEPTH`=4, and drive `rx` on bit boundaries.
- Reset, then one frame 0xA5 with valid stop:
  - After the stop midpoint: `empty`=0 and `rd_data`=0xA5.
  - Pulse `rd_en`: `empty`=1.
- Five frames 0x01..0x05 with no reads:
  - `full`=1 after 0x04.
  - `overrun` pulses once at the 5th stop.
  - Pops return 0x01..0x04 in order.
- Frame 0x3C with the stop bit driven 0:
  - `frame_err` pulses for 1 cycle.
  - `empty` stays 1.
- 4-cycle low glitch on `rx` in idle:
  - No push, no error pulses.
  - A valid frame 0x7E immediately after is received correctly.
- FIFO full, with `rd_en`=1 held on the cycle of a new byte's stop sample:
  - No `overrun`; `full` stays 1.
  - The oldest byte leaves and the new byte is at the tail.
- `ena` dropped to 0 mid-data of frame 0x55, then a full frame 0x99 with `ena`=1:
  - Only 0x99 is pushed; no error pulses.
  - With `UART_RX_PARITY_EN`: frame 0x99 with wrong parity gives a `parity_err` pulse and no push.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8-N-1 UART receiver feeding a first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to receive 8-E-1 frames with parity checking.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic s1, rx_s, rx_q;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic perr;
  logic [7:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic tick, pop, stop_hit, push;
  assign tick = cnt == '0;
  assign pop = rd_en && !empty;
  assign stop_hit = ena && state == STOP && tick;
  assign push = stop_hit && rx_s && !perr && (!full || pop);
  assign rd_data = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {s1, rx_s, rx_q} <= 3'b111;
    else {s1, rx_s, rx_q} <= {rx, s1, rx_s};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun <= 1'b0;
      if (!ena) begin
        state <= IDLE;
        cnt <= '0;
        bit_idx <= '0;
      end else case (state)
        IDLE: if (rx_q && !rx_s) begin
          cnt <= CW'(CLKS_PER_BIT / 2 - 1);
          state <= START;
        end
        START: if (!tick) cnt <= cnt - 1'b1;
        else begin
          cnt <= CW'(CLKS_PER_BIT - 1);
          bit_idx <= '0;
          state <= rx_s ? IDLE : DATA;
        end
        DATA: if (!tick) cnt <= cnt - 1'b1;
        else begin
          cnt <= CW'(CLKS_PER_BIT - 1);
          sh <= {rx_s, sh[7:1]};
          bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (!tick) cnt <= cnt - 1'b1;
        else begin
          cnt <= CW'(CLKS_PER_BIT - 1);
          state <= STOP;
        end
`endif
        STOP: if (!tick) cnt <= cnt - 1'b1;
        else begin
          state <= IDLE;
          frame_err <= !rx_s;
          overrun <= rx_s && !perr && full && !pop;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perr <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= stop_hit && rx_s && perr;
      if (state == IDLE) perr <= 1'b0;
      else if (ena && state == PARITY && tick) perr <= rx_s ^ (^sh);
    end
`else
  assign perr = 1'b0;
  assign parity_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= sh;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed checks of uart_rx_fifo with CLKS_PER_BIT=8, DEPTH=4.
module tb_uart_rx_fifo;
  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
  logic bad_par = 1'b0;
`else
  localparam int NB = 10;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1, rx = 1'b1, rd_en = 1'b0;
  logic [7:0] rd_data;
  logic empty, full, overrun, frame_err, parity_err;
  int n_asrt = 0, n_fail = 0, n_ovr = 0, n_fe = 0, n_pe = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .overrun(overrun),
    .frame_err(frame_err), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (overrun) n_ovr <= n_ovr + 1;
    if (frame_err) n_fe <= n_fe + 1;
    if (parity_err) n_pe <= n_pe + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ bad_par;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    chk(tag, rd_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_data", rd_data, 8'h00);
    chk("rst_pulses", {overrun, frame_err, parity_err}, 3'b000);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send(8'hA5, 1'b1);
    chk("a5_empty", empty, 0);
    pop("a5_data", 8'hA5);
    chk("a5_popped", empty, 1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    chk("pop_on_empty", {empty, full}, 2'b10);

    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
    chk("fill_full", full, 1);
    chk("fill_no_ovr", n_ovr, 0);
    send(8'h05, 1'b1);
    chk("ovr_once", n_ovr, 1);
    chk("ovr_still_full", full, 1);
    for (int i = 1; i <= 4; i++) pop("fill_order", 8'(i));
    chk("fill_drained", empty, 1);

    send(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    chk("fe_pulse", n_fe, 1);
    chk("fe_no_push", empty, 1);

    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    chk("glitch_no_push", empty, 1);
    chk("glitch_no_err", n_fe + n_ovr + n_pe, 2);
    send(8'h7E, 1'b1);
    pop("glitch_next", 8'h7E);
    chk("glitch_drained", empty, 1);

    for (int i = 1; i <= 4; i++) send(8'(8'h10 + i), 1'b1);
    chk("pp_full", full, 1);
    fork
      send(8'h15, 1'b1);
      begin
        repeat (8 * NB - 2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join
    chk("pp_no_ovr", n_ovr, 1);
    chk("pp_still_full", full, 1);
    for (int i = 2; i <= 5; i++) pop("pp_order", 8'(8'h10 + i));
    chk("pp_drained", empty, 1);

    fork
      send(8'h55, 1'b1);
      begin
        repeat (30) @(negedge clk);
        ena = 1'b0;
      end
    join
    chk("ena_no_push", empty, 1);
    ena = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h99, 1'b1);
    pop("ena_data", 8'h99);
    chk("ena_one_byte", empty, 1);
    chk("ena_no_err", {n_ovr, n_fe, n_pe}, {32'd1, 32'd1, 32'd0});

`ifdef UART_RX_PARITY_EN
    bad_par = 1'b1;
    send(8'h99, 1'b1);
    bad_par = 1'b0;
    repeat (4) @(negedge clk);
    chk("pe_pulse", n_pe, 1);
    chk("pe_no_push", empty, 1);
    chk("pe_no_fe", n_fe, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
